fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have ports: fast_clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: top_en  in  1  global run enable; 0 freezes the block (infer still honoured).
REQ-004 SHALL have ports: infer  in  1  level; force PC to infer_addr.
REQ-005 SHALL have ports: infer_addr  in  10  PC load value while infer=1.
REQ-006 SHALL have ports: if_stb / ju_stb / br_stb / sk_stb  in  1 each  one-cycle stage strobes from the control unit (IF, JU, BR, SK).
REQ-007 SHALL have ports: br_taken  in  1  branch condition, sampled with br_stb.
REQ-008 SHALL have ports: br_offset  in  10  two's-complement word offset.
REQ-009 SHALL have ports: ju_target  in  10  absolute jump word address.
REQ-010 SHALL have ports: imem_en  out  1  instruction memory read enable.
REQ-011 SHALL have ports: imem_addr  out  10  instruction memory word address.
REQ-012 SHALL have ports: imem_rdata  in  32  memory data, valid one cycle after imem_en.
REQ-013 SHALL have ports: pc  out  10  current PC.
REQ-014 SHALL have ports: instr  out  32  instruction register.
REQ-015 SHALL have ports: instr_valid  out  1  instr holds a completed fetch.
REQ-016 SHALL have ports: fetch_ovr  out  1  sticky: if_stb seen in WAIT.
REQ-017 SHALL have ports: fetch_cnt / redir_cnt  out  16 each  performance counters.

Function
REQ-018 SHALL implement FSM IDLE, WAIT, HOLD.
REQ-019 IDLE/HOLD + if_stb -> WAIT; same cycle imem_en=1, imem_addr=pc (combinational).
REQ-020 WAIT -> HOLD unconditionally next cycle; instr<=imem_rdata, instr_valid<=1, pc<=pc+1 mod 1024; total fetch latency 2 cycles strobe to instr_valid.
REQ-021 imem_en SHALL be 1 only in the cycle of an accepted if_stb.
REQ-022 if_stb in WAIT SHALL be ignored and set fetch_ovr (cleared only by reset).
REQ-023 ju_stb -> pc<=ju_target next cycle.
REQ-024 br_stb & br_taken -> pc<=pc+br_offset mod 1024; br_stb & !br_taken -> pc unchanged.
REQ-025 sk_stb -> pc<=pc+1 mod 1024.
REQ-026 Redirect priority within one cycle: infer > ju_stb > br_stb(taken) > sk_stb; lower ones dropped.
REQ-027 Redirect in the WAIT->HOLD cycle SHALL win over the +1 increment; instr still captured.
REQ-028 infer=1: pc<=infer_addr every cycle, FSM->IDLE, instr_valid<=0, imem_en=0, all strobes ignored, regardless of top_en.
REQ-029 top_en=0 and infer=0: state, pc, instr, counters hold; strobes ignored; an in-flight WAIT still completes its capture.
REQ-030 All PC arithmetic SHALL be 10-bit modulo (1023+1 -> 0; 0+(-1) -> 1023).

Reset
REQ-031 rst_n=0 SHALL asynchronously set FSM=IDLE, pc=0, instr=0, instr_valid=0, fetch_ovr=0, counters=0, imem_en=0; reset mid-fetch aborts the capture.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: fetch_cnt increments per completed capture, redir_cnt per applied JU/taken BR/SK; both saturate at 16'hFFFF.
REQ-033 Macro undefined: ports exist, tied to 0, no counter flops.

Verification
REQ-034 Reset, if_stb at pc=0, imem_rdata=32'h2002000A -> imem_en one cycle at addr 0; 2 cycles later instr=32'h2002000A, instr_valid=1, pc=1.
REQ-035 pc=5, br_stb, br_taken=1, br_offset=10'h3FC (-4) -> pc=1; br_taken=0 -> pc stays 5.
REQ-036 pc=1023, if_stb then capture -> pc=0; pc=1023, sk_stb -> pc=0.
REQ-037 ju_stb(target 200) and sk_stb same cycle -> pc=200, redir_cnt +1 (with FETCH_PERF_CNT_EN).
REQ-038 infer=1, infer_addr=1 during WAIT -> next cycle pc=1, FSM IDLE, instr_valid=0, no capture; if_stb in WAIT otherwise -> fetch_ovr=1.
REQ-039 rst_n low mid-WAIT -> all outputs reset immediately without waiting for fast_clk.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch sequencer: IDLE/WAIT/HOLD fetch FSM with jump, branch and skip redirects.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit (
    input  logic        fast_clk,
    input  logic        rst_n,
    input  logic        top_en,
    input  logic        infer,
    input  logic [9:0]  infer_addr,
    input  logic        if_stb,
    input  logic        ju_stb,
    input  logic        br_stb,
    input  logic        sk_stb,
    input  logic        br_taken,
    input  logic [9:0]  br_offset,
    input  logic [9:0]  ju_target,
    output logic        imem_en,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [9:0]  pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_ovr,
    output logic [15:0] fetch_cnt,
    output logic [15:0] redir_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  pc_nxt;
    logic        run;
    logic        fetch_go;
    logic        capture;
    logic        redir_ju, redir_br, redir_sk, redir_any;

    // infer overrides everything; top_en only gates new work, never an in-flight capture
    assign run       = top_en & ~infer;
    assign fetch_go  = run & if_stb & (state != S_WAIT);
    assign capture   = (state == S_WAIT) & ~infer;

    assign redir_ju  = run & ju_stb;
    assign redir_br  = run & ~ju_stb & br_stb & br_taken;
    assign redir_sk  = run & ~ju_stb & ~(br_stb & br_taken) & sk_stb;
    assign redir_any = redir_ju | redir_br | redir_sk;

    assign imem_en   = fetch_go;
    assign imem_addr = pc;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        pc_nxt    = pc;
        if (infer) begin
            state_nxt = S_IDLE;
            pc_nxt    = infer_addr;
        end else begin
            case (state)
                S_IDLE, S_HOLD: if (fetch_go) state_nxt = S_WAIT;
                S_WAIT:         state_nxt = S_HOLD;
                default:        state_nxt = S_IDLE;
            endcase
            // 10-bit adders wrap naturally, giving modulo-1024 PC arithmetic
            if (redir_ju)      pc_nxt = ju_target;
            else if (redir_br) pc_nxt = pc + br_offset;
            else if (redir_sk) pc_nxt = pc + 10'd1;
            else if (capture)  pc_nxt = pc + 10'd1;
        end
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_ovr   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (infer) begin
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (run && if_stb && state == S_WAIT)
                fetch_ovr <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (capture && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'd1;
            if (redir_any && redir_cnt != 16'hFFFF)
                redir_cnt <= redir_cnt + 16'd1;
        end
    end
`else
    assign fetch_cnt = '0;
    assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: fetch latency, redirects, priorities, wrap-around, infer, enable and reset.
module tb_fetch_pc_unit;

    logic        fast_clk = 1'b0;
    logic        rst_n;
    logic        top_en, infer, if_stb, ju_stb, br_stb, sk_stb, br_taken;
    logic [9:0]  infer_addr, br_offset, ju_target;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [9:0]  pc;
    logic [31:0] instr;
    logic        instr_valid, fetch_ovr;
    logic [15:0] fetch_cnt, redir_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_pc_unit dut (
        .fast_clk   (fast_clk),
        .rst_n      (rst_n),
        .top_en     (top_en),
        .infer      (infer),
        .infer_addr (infer_addr),
        .if_stb     (if_stb),
        .ju_stb     (ju_stb),
        .br_stb     (br_stb),
        .sk_stb     (sk_stb),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .ju_target  (ju_target),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .fetch_ovr  (fetch_ovr),
        .fetch_cnt  (fetch_cnt),
        .redir_cnt  (redir_cnt)
    );

    always #5 fast_clk = ~fast_clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return (a == 10'd0) ? 32'h2002000A : {16'hC0DE, 6'd0, a};
    endfunction

    // Synchronous-read instruction memory: data appears the cycle after imem_en
    always @(posedge fast_clk)
        if (imem_en) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic force_pc(input logic [9:0] a);
        infer = 1'b1; infer_addr = a;
        step();
        infer = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; top_en = 1'b0; infer = 1'b0; infer_addr = '0;
        if_stb = 1'b0; ju_stb = 1'b0; br_stb = 1'b0; sk_stb = 1'b0;
        br_taken = 1'b0; br_offset = '0; ju_target = '0;
        #12;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ovr", 32'(fetch_ovr), 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_fcnt", 32'(fetch_cnt), 32'd0);
        check("rst_rcnt", 32'(redir_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic fetch at pc=0: two-cycle latency
        top_en = 1'b1; if_stb = 1'b1;
        #1;
        check("fetch0_en", 32'(imem_en), 32'd1);
        check("fetch0_addr", 32'(imem_addr), 32'd0);
        step();
        if_stb = 1'b0;
        #1;
        check("fetch0_en_drop", 32'(imem_en), 32'd0);
        check("fetch0_wait_valid", 32'(instr_valid), 32'd0);
        step();
        check("fetch0_instr", instr, 32'h2002000A);
        check("fetch0_valid", 32'(instr_valid), 32'd1);
        check("fetch0_pc", 32'(pc), 32'd1);

        // Branch taken / not taken from pc=5
        force_pc(10'd5);
        check("infer_pc5", 32'(pc), 32'd5);
        check("infer_valid_clr", 32'(instr_valid), 32'd0);
        br_stb = 1'b1; br_taken = 1'b1; br_offset = 10'h3FC;
        step();
        br_stb = 1'b0;
        check("br_taken_pc", 32'(pc), 32'd1);
        force_pc(10'd5);
        br_stb = 1'b1; br_taken = 1'b0;
        step();
        br_stb = 1'b0;
        check("br_not_taken_pc", 32'(pc), 32'd5);

        // Wrap at 1023: capture increment and skip
        force_pc(10'd1023);
        if_stb = 1'b1;
        step();
        if_stb = 1'b0;
        step();
        check("wrap_fetch_pc", 32'(pc), 32'd0);
        check("wrap_fetch_instr", instr, 32'hC0DE03FF);
        force_pc(10'd1023);
        sk_stb = 1'b1;
        step();
        sk_stb = 1'b0;
        check("wrap_skip_pc", 32'(pc), 32'd0);

        // Jump beats skip in the same cycle
        ju_stb = 1'b1; ju_target = 10'd200; sk_stb = 1'b1;
        step();
        ju_stb = 1'b0; sk_stb = 1'b0;
        check("ju_over_sk_pc", 32'(pc), 32'd200);
`ifdef FETCH_PERF_CNT_EN
        check("redir_cnt", 32'(redir_cnt), 32'd3);
        check("fetch_cnt", 32'(fetch_cnt), 32'd2);
`else
        check("redir_cnt_tied", 32'(redir_cnt), 32'd0);
        check("fetch_cnt_tied", 32'(fetch_cnt), 32'd0);
`endif

        // if_stb during WAIT is ignored and flags fetch_ovr
        if_stb = 1'b1;
        step();
        #1;
        check("ovr_no_en", 32'(imem_en), 32'd0);
        step();
        if_stb = 1'b0;
        check("ovr_flag", 32'(fetch_ovr), 32'd1);
        check("ovr_pc", 32'(pc), 32'd201);
        check("ovr_instr", instr, 32'hC0DE00C8);

        // Jump in the capture cycle wins over +1, instruction still captured
        if_stb = 1'b1;
        step();
        if_stb = 1'b0; ju_stb = 1'b1; ju_target = 10'd50;
        step();
        ju_stb = 1'b0;
        check("wait_ju_pc", 32'(pc), 32'd50);
        check("wait_ju_instr", instr, 32'hC0DE00C9);
        check("wait_ju_valid", 32'(instr_valid), 32'd1);

        // infer during WAIT aborts the capture
        if_stb = 1'b1;
        step();
        if_stb = 1'b0;
        force_pc(10'd1);
        check("infer_wait_pc", 32'(pc), 32'd1);
        check("infer_wait_valid", 32'(instr_valid), 32'd0);
        check("infer_wait_instr", instr, 32'hC0DE00C9);
        step();
        check("infer_idle_pc", 32'(pc), 32'd1);
        check("infer_idle_valid", 32'(instr_valid), 32'd0);

        // top_en=0 freezes PC and blocks fetch
        top_en = 1'b0; sk_stb = 1'b1; if_stb = 1'b1;
        #1;
        check("frozen_no_en", 32'(imem_en), 32'd0);
        step();
        sk_stb = 1'b0; if_stb = 1'b0;
        check("frozen_pc", 32'(pc), 32'd1);
        check("frozen_valid", 32'(instr_valid), 32'd0);

        // Asynchronous reset mid-WAIT
        top_en = 1'b1; if_stb = 1'b1;
        step();
        if_stb = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_pc", 32'(pc), 32'd0);
        check("amid_instr", instr, 32'd0);
        check("amid_valid", 32'(instr_valid), 32'd0);
        check("amid_ovr", 32'(fetch_ovr), 32'd0);
        check("amid_en", 32'(imem_en), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        check("after_rst_valid", 32'(instr_valid), 32'd0);
        check("after_rst_pc", 32'(pc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
